// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, instruction RAM addressing, IR capture and valid/ready hand-off.
// Optional speculative next-word fetch with a one-entry buffer: define INSTR_FETCH_PREFETCH_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 9,
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 6,
  parameter int HALT_OPC = 46,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [OPC_W-1:0]           opcode,
  output logic [INSTR_W-OPC_W-1:0]   operand,
  output logic [ADDR_W-1:0]          pc_out,
  input  logic                       branch_take,
  input  logic [9:0]                 branch_addr,
  output logic                       busy,
  output logic                       halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_CAPT   = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0]   br_target;
  logic                accept;
  logic                is_halt;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [INSTR_W-1:0]  buf_q, buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic                pend_q, pend_d;
  logic                have_data;
  logic                issue;
`endif

  assign accept    = (state_q == S_HOLD) && ir_ready;
  assign is_halt   = (ir_q[INSTR_W-1 -: OPC_W] == OPC_W'(HALT_OPC));
  assign br_target = branch_addr[ADDR_W-1:0];

  if (ADDR_W < 10) begin : g_unused_ba
    logic unused_ba;
    assign unused_ba = ^branch_addr[9:ADDR_W];
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  // pc_q is the next address to request; a new request is issued only when
  // its returning word is guaranteed a slot (IR or buffer).
  assign have_data = buf_vld_q || pend_q;
  assign issue     = (state_q == S_CAPT) ||
                     ((state_q == S_HOLD) &&
                      (accept ? !(buf_vld_q && pend_q) : !have_data));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_REQ;
      S_REQ:            state_d = S_CAPT;
      S_CAPT:           state_d = S_HOLD;
      S_HOLD: begin
        if (accept) begin
          if (is_halt)          state_d = S_HALTED;
          else if (branch_take) state_d = S_REQ;
          else begin
`ifdef INSTR_FETCH_PREFETCH_EN
            state_d = have_data ? S_HOLD : S_REQ;
`else
            state_d = S_REQ;
`endif
          end
        end
      end
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_addr = pc_q;
    ir_valid  = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    halted    = (state_q == S_HALTED);
    opcode    = ir_q[INSTR_W-1 -: OPC_W];
    operand   = ir_q[INSTR_W-OPC_W-1:0];
    pc_out    = pc_out_q;
  end

  always_comb begin
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    pend_d    = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d      = ADDR_W'(RESET_PC);
          buf_vld_d = 1'b0;
        end
      end
      S_REQ: pc_d = pc_q + ADDR_W'(1);
      S_CAPT: begin
        ir_d      = imem_data;
        pc_out_d  = pc_q - ADDR_W'(1);
        pc_d      = pc_q + ADDR_W'(1);
        pend_d    = 1'b1;
        buf_vld_d = 1'b0;
      end
      S_HOLD: begin
        if (accept) begin
          buf_vld_d = 1'b0;
          if (is_halt) begin
            pend_d = 1'b0;
          end else if (branch_take) begin
            pc_d = br_target;
          end else begin
            pc_out_d = pc_out_q + ADDR_W'(1);
            pend_d   = issue;
            if (issue) pc_d = pc_q + ADDR_W'(1);
            if (buf_vld_q) begin
              ir_d = buf_q;
              if (pend_q) begin
                buf_d     = imem_data;
                buf_vld_d = 1'b1;
              end
            end else if (pend_q) begin
              ir_d = imem_data;
            end else begin
              pc_d   = pc_out_q + ADDR_W'(1);
              pend_d = 1'b0;
            end
          end
        end else begin
          if (pend_q) begin
            buf_d     = imem_data;
            buf_vld_d = 1'b1;
          end
          pend_d = issue;
          if (issue) pc_d = pc_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
`else
    case (state_q)
      S_IDLE, S_HALTED: if (start) pc_d = ADDR_W'(RESET_PC);
      S_CAPT: begin
        ir_d     = imem_data;
        pc_out_d = pc_q;
        pc_d     = pc_q + ADDR_W'(1);
      end
      S_HOLD: if (accept && !is_halt && branch_take) pc_d = br_target;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= ADDR_W'(RESET_PC);
      pc_out_q  <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      pend_q    <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      ir_q      <= ir_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      pend_q    <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (default build) with a registered-read instruction RAM model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, ir_valid, ir_ready, branch_take, busy, halted;
  logic [8:0]  imem_addr, pc_out;
  logic [15:0] imem_data;
  logic [5:0]  opcode;
  logic [9:0]  operand, branch_addr;
  logic [15:0] mem [512];

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .opcode(opcode), .operand(operand), .pc_out(pc_out),
    .branch_take(branch_take), .branch_addr(branch_addr),
    .busy(busy), .halted(halted)
  );

  function automatic logic [15:0] w(input int opc, input int opd);
    return 16'((opc << 10) | opd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!ir_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("valid_timeout", {31'd0, ir_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    mem[0]   = w(2, 0);
    mem[1]   = w(4, 0);
    mem[2]   = w(6, 0);
    mem[3]   = w(19, 30);
    mem[4]   = w(52, 159);
    mem[159] = w(10, 3);
    mem[160] = w(12, 0);
    mem[161] = w(13, 0);
    mem[162] = w(14, 0);
    mem[163] = w(15, 0);
    mem[164] = w(46, 0);
    mem[511] = w(20, 7);

    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; branch_take = 1'b0; branch_addr = '0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    chk("rst_valid",   ir_valid,  0);
    chk("rst_busy",    busy,      0);
    chk("rst_halted",  halted,    0);
    chk("rst_addr",    imem_addr, 0);
    chk("rst_opcode",  opcode,    0);
    chk("rst_operand", operand,   0);
    chk("rst_pc_out",  pc_out,    0);

    // sequential fetch
    start = 1'b1; tick(); start = 1'b0;
    chk("req_addr",  imem_addr, 0);
    chk("req_busy",  busy,      1);
    chk("req_valid", ir_valid,  0);
    tick();
    chk("capt_valid", ir_valid, 0);
    tick();
    chk("first_valid", ir_valid, 1);
    chk("seq0_opc",    opcode,   2);
    chk("seq0_pc",     pc_out,   0);
    ir_ready = 1'b1;
    tick();
    chk("after_acc_valid", ir_valid,  0);
    chk("after_acc_addr",  imem_addr, 1);
    wait_valid(n);
    chk("gap1",     n + 1,  3);
    chk("seq1_opc", opcode, 4);
    chk("seq1_pc",  pc_out, 1);
    tick();
    wait_valid(n);
    chk("gap2",     n + 1,  3);
    chk("seq2_opc", opcode, 6);
    chk("seq2_pc",  pc_out, 2);

    // backpressure on word 3, with an ignored start pulse
    tick();
    ir_ready = 1'b0;
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      chk("bp_valid",   ir_valid,  1);
      chk("bp_opcode",  opcode,    19);
      chk("bp_operand", operand,   30);
      chk("bp_pc",      pc_out,    3);
      chk("bp_addr",    imem_addr, 4);
      tick();
    end
    start = 1'b0;
    chk("bp_end_opc", opcode, 19);
    ir_ready = 1'b1;
    tick();
    chk("bp_next_req_valid", ir_valid,  0);
    chk("bp_next_req_addr",  imem_addr, 4);
    chk("bp_next_req_busy",  busy,      1);

    // taken branch to 159
    wait_valid(n);
    chk("br_src_opc", opcode,  52);
    chk("br_src_pc",  pc_out,  4);
    branch_take = 1'b1; branch_addr = 10'd159;
    tick();
    branch_take = 1'b0;
    chk("br_req_addr", imem_addr, 159);
    wait_valid(n);
    chk("br_tgt_pc",  pc_out,  159);
    chk("br_tgt_opc", opcode,  10);
    chk("br_tgt_opd", operand, 3);

    // run on to HALT at 164
    for (int i = 160; i <= 164; i++) begin
      tick();
      wait_valid(n);
      chk("run_pc", pc_out, 32'(i));
      chk("run_opc", opcode, (i == 164) ? 32'd46 : 32'(i - 148));
    end
    branch_take = 1'b1; branch_addr = 10'd300;
    tick();
    branch_take = 1'b0;
    chk("halt_halted", halted,   1);
    chk("halt_busy",   busy,     0);
    chk("halt_valid",  ir_valid, 0);
    tick(); tick();
    chk("halt_stay_valid",  ir_valid, 0);
    chk("halt_stay_halted", halted,   1);

    // restart from HALTED
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_halted", halted,    0);
    chk("restart_busy",   busy,      1);
    chk("restart_addr",   imem_addr, 0);
    wait_valid(n);
    chk("restart_lat", n, 2);
    chk("restart_pc",  pc_out, 0);
    chk("restart_opc", opcode, 2);

    // reset while in CAPT of word 1
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid",  ir_valid,  0);
    chk("mrst_busy",   busy,      0);
    chk("mrst_addr",   imem_addr, 0);
    chk("mrst_opcode", opcode,    0);
    chk("mrst_pc",     pc_out,    0);
    tick(); tick(); tick();
    chk("mrst_idle_valid", ir_valid, 0);
    chk("mrst_idle_busy",  busy,     0);

    // PC wrap through 511
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    chk("wrap_src_pc", pc_out, 0);
    branch_take = 1'b1; branch_addr = 10'd511;
    tick();
    branch_take = 1'b0;
    wait_valid(n);
    chk("wrap_tgt_pc",  pc_out,  511);
    chk("wrap_tgt_opc", opcode,  20);
    chk("wrap_tgt_opd", operand, 7);
    tick();
    wait_valid(n);
    chk("wrap_next_pc",  pc_out, 0);
    chk("wrap_next_opc", opcode, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage between the 16-bit instruction RAM (registered read, one-cycle latency) and the microcoded control unit. Holds the program counter, drives the RAM address, captures each returned word and splits it into a 6-bit opcode and a 10-bit operand. Presents the instruction to the control unit through a valid/ready handshake, redirects on taken jumps, and stops on the end-of-program opcode.

## Interface
Parameters:
- ADDR_W, 9, PC and RAM address width
- INSTR_W, 16, instruction word width
- OPC_W, 6, opcode field width, bits [15:10]; operand is bits [9:0]
- HALT_OPC, 46, opcode that ends the program
- RESET_PC, 0, start address

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin fetching from RESET_PC; honoured only in IDLE or HALTED
- imem_addr  out  ADDR_W  instruction RAM address
- imem_data  in  INSTR_W  RAM read data, valid one cycle after imem_addr
- ir_valid  out  1  opcode/operand/pc_out hold a valid instruction
- ir_ready  in  1  control unit accepts the instruction
- opcode  out  OPC_W  instruction [15:10]
- operand  out  10  instruction [9:0]
- pc_out  out  ADDR_W  address of the presented instruction
- branch_take  in  1  sampled only at acceptance; redirect to branch_addr
- branch_addr  in  10  jump target; bits [ADDR_W-1:0] used
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  HALT_OPC instruction has been accepted

## Operation
- States: IDLE, REQ, CAPT, HOLD, HALTED.
- IDLE: imem_addr = pc. On start, pc <= RESET_PC and the next state is REQ.
- REQ: imem_addr = pc. Next state is CAPT.
- CAPT: imem_data is valid. The IR register loads it, pc <= pc+1, and the next state is HOLD.
- HOLD: ir_valid = 1. Opcode, operand and pc_out stay stable until accepted (ir_valid & ir_ready).
- On acceptance with branch_take = 1, pc <= branch_addr[ADDR_W-1:0].
- On acceptance with opcode == HALT_OPC, the next state is HALTED and branch_take is ignored.
- On any other acceptance, the next state is REQ.
- HALTED: halted = 1, ir_valid = 0. A start pulse clears halted and restarts from RESET_PC.
- start outside IDLE and HALTED is ignored.
- The PC is ADDR_W-bit unsigned and wraps 2^ADDR_W-1 -> 0. There is no bounds check against RAM depth.
- Fields are pure slices of the word; no decoding beyond the HALT compare.
- Reset, at any state and mid-fetch:
  - next edge: state IDLE, pc = RESET_PC, IR = 0, ir_valid = 0, busy = 0, halted = 0, imem_addr = RESET_PC;
  - in-flight RAM data is discarded.
- Reset values: opcode = 0, operand = 0, pc_out = RESET_PC.

## Timing
- start sampled at edge 0 → imem_addr = RESET_PC in cycle 1 (REQ) → data captured at the end of cycle 2 (CAPT) → ir_valid = 1 from cycle 3.
- Baseline throughput is one instruction per 3 cycles with ir_ready held high.
- Acceptance at edge k:
  - if not HALT, a fetch of the next pc (sequential or branch target) starts in cycle k+1;
  - if HALT, halted = 1 in cycle k+1.
- ir_valid never drops without acceptance, and outputs never change while ir_valid & !ir_ready.

## Configuration
- INSTR_FETCH_PREFETCH_EN undefined: behaviour exactly as above.
- INSTR_FETCH_PREFETCH_EN defined:
  - imem_addr is driven with pc+1 during CAPT and HOLD, so the next word is speculatively fetched.
  - A one-entry prefetch buffer keeps the returned word while the IR is stalled.
  - With ir_ready held high and no branches, one instruction is accepted per cycle after the first.
  - Taken branch: the prefetched word is discarded; ir_valid is low for exactly 2 cycles, then the target instruction is presented.
  - Accepting HALT_OPC discards the prefetched word; no instruction beyond HALT is ever presented.
  - The handshake rules and reset values are unchanged.

## Test plan
- Sequential fetch: RAM words at 0..2 = {2,0},{4,0},{6,0}, start, ir_ready = 1 → opcodes 2,4,6 at pc_out 0,1,2. First ir_valid 3 cycles after start; baseline gap 3 cycles.
- Backpressure: hold ir_ready = 0 for 5 cycles on word {19,30} → opcode 19 and operand 30 stable, no pc advance. Accept → next fetch starts the following cycle.
- Branch: accept {52,159} with branch_take = 1, branch_addr = 159 → next presented pc_out = 159. Under PREFETCH_EN, ir_valid is low for exactly 2 cycles before it.
- Halt: accept {46,0} at pc 164 → halted = 1, busy = 0 next cycle, ir_valid stays 0. A start pulse restarts at pc_out 0.
- Reset mid-operation: rst_n low during CAPT → next edge ir_valid = 0, state IDLE, imem_addr = 0. The old word is never presented.
- Wrap: branch to 511, accept → next pc_out = 0.
